priority_event_encoder: RTL and testbench

//  Sequential, parametrised priority encoder for event/interrupt-style request lines.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_select.sv | 48 ++++
 rtl/priority_event_encoder.sv | 94 +++++++++
 tb/tb_priority_event_encoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the priority event encoder.
// Holds the priority mode enum and the one-hot to binary encode.
// Encode helper is width-agnostic up to PE_MAX_WIDTH request lines.
package pe_pkg;

  typedef enum logic {
    PE_FIXED = 1'b0,
    PE_RR    = 1'b1
  } pe_mode_e;

  localparam int PE_MAX_WIDTH = 64;

  // OR-reduction encode: exact for a one-hot input, returns 0 for all-zero.
  function automatic int onehot_to_idx(input logic [PE_MAX_WIDTH-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < PE_MAX_WIDTH; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pe_select.sv
// Picks one set bit of the pending vector, searching downward from a start index.
// Purely combinational: zero latency, no backpressure of its own.
// Rotate so the start index lands on the MSB, take the highest set bit, rotate back.
module pe_select
  import pe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OUT_BITS = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]    pending_i,
  input  logic [OUT_BITS-1:0] start_i,
  input  pe_mode_e            mode_i,
  output logic                any_set_o,
  output logic [OUT_BITS-1:0] sel_idx_o,
  output logic [WIDTH-1:0]    sel_onehot_o
);

  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] rot_hit;
  logic             found;
  int               base;

  // Rotate, find highest set bit, unrotate. Fixed mode always starts at WIDTH-1 (base 0).
  always_comb begin
    rot          = '0;
    rot_hit      = '0;
    found        = 1'b0;
    sel_onehot_o = '0;
    // rot[j] = pending[(start+1+j) mod WIDTH], so rot's MSB is the start index
    base = (mode_i == PE_FIXED) ? 0 : ((int'(start_i) + 1) % WIDTH);
    for (int j = 0; j < WIDTH; j++) begin
      rot[j] = pending_i[(base + j) % WIDTH];
    end
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (!found && rot[j]) begin
        rot_hit[j] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      sel_onehot_o[(base + j) % WIDTH] = rot_hit[j];
    end
  end

  assign any_set_o = |pending_i;
  assign sel_idx_o = OUT_BITS'(onehot_to_idx(PE_MAX_WIDTH'(sel_onehot_o)));

endmodule

// File: rtl/priority_event_encoder.sv
// Collects request pulses into a sticky pending vector and emits one index at a time.
// Latency: pulse visible in pending after 1 edge, on out_idx after 2 edges; 1 index/cycle.
// Backpressure: out_valid && !out_ready holds the slot stable while pending keeps accumulating.
module priority_event_encoder
  import pe_pkg::*;
#(
  parameter int       WIDTH    = 8,
  parameter int       OUT_BITS = $clog2(WIDTH),
  parameter pe_mode_e MODE     = PE_FIXED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    req_in,
  output logic [OUT_BITS-1:0] out_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    pending_o,
  output logic                merge_o
);

  if (WIDTH < 2) begin : g_bad_width
    $error("priority_event_encoder: WIDTH must be at least 2");
  end
  if (WIDTH > PE_MAX_WIDTH) begin : g_too_wide
    $error("priority_event_encoder: WIDTH exceeds PE_MAX_WIDTH");
  end
  if (OUT_BITS < $clog2(WIDTH)) begin : g_bad_out_bits
    $error("priority_event_encoder: OUT_BITS too small for WIDTH");
  end

  logic [WIDTH-1:0]    pending_q, pending_d;
  logic [OUT_BITS-1:0] out_idx_q, out_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                merge_q, merge_d;

  logic [OUT_BITS-1:0] sel_start;
  logic                any_set;
  logic [OUT_BITS-1:0] sel_idx;
  logic [WIDTH-1:0]    sel_onehot;
  logic                slot_free;
  logic                load;

  // Round-robin search begins one below the last grant, wrapping 0 -> WIDTH-1.
  assign sel_start = (rr_ptr_q == '0) ? OUT_BITS'(WIDTH - 1) : (rr_ptr_q - 1'b1);

  pe_select #(
    .WIDTH    (WIDTH),
    .OUT_BITS (OUT_BITS)
  ) u_select (
    .pending_i    (pending_q),
    .start_i      (sel_start),
    .mode_i       (MODE),
    .any_set_o    (any_set),
    .sel_idx_o    (sel_idx),
    .sel_onehot_o (sel_onehot)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign load      = slot_free && any_set;

  // Next state: set wins over the load-clear, so a re-fire on the loaded line stays pending.
  always_comb begin
    pending_d   = (pending_q & ~(load ? sel_onehot : '0)) | req_in;
    out_valid_d = slot_free ? any_set : out_valid_q;
    out_idx_d   = load ? sel_idx : out_idx_q;
    rr_ptr_d    = load ? sel_idx : rr_ptr_q;
    // Only a hit on a still-pending line collapses; a line sitting in the slot is a re-arm.
    merge_d     = |(req_in & pending_q);
  end

  // All state in one register bank; reset drops any event held in the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= OUT_BITS'(WIDTH - 1);
      merge_q     <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      merge_q     <= merge_d;
    end
  end

  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign pending_o = pending_q;
  assign merge_o   = merge_q;

endmodule

// File: tb/tb_priority_event_encoder.sv
// Directed bench for priority_event_encoder: one fixed-priority and one round-robin instance.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Each step's expected value is hand-computed from the behaviour description.
module tb_priority_event_encoder;
  import pe_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] req_f, req_r;
  logic       rdy_f, rdy_r;
  logic [2:0] idx_f, idx_r;
  logic       vld_f, vld_r;
  logic [7:0] pend_f, pend_r;
  logic       merge_f, merge_r;

  int checks;
  int failures;

  priority_event_encoder #(.WIDTH(8), .OUT_BITS(3), .MODE(PE_FIXED)) u_fixed (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_f),
    .out_idx   (idx_f),
    .out_valid (vld_f),
    .out_ready (rdy_f),
    .pending_o (pend_f),
    .merge_o   (merge_f)
  );

  priority_event_encoder #(.WIDTH(8), .OUT_BITS(3), .MODE(PE_RR)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_r),
    .out_idx   (idx_r),
    .out_valid (vld_r),
    .out_ready (rdy_r),
    .pending_o (pend_r),
    .merge_o   (merge_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_idx;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    req_f = 8'h00;
    req_r = 8'h00;
    rdy_f = 1'b1;
    rdy_r = 1'b1;
    tick();
    tick();

    // Reset state
    check_eq("rst_vld_f", 32'(vld_f), 32'h0);
    check_eq("rst_idx_f", 32'(idx_f), 32'h0);
    check_eq("rst_pend_f", 32'(pend_f), 32'h0);
    check_eq("rst_merge_f", 32'(merge_f), 32'h0);
    check_eq("rst_vld_r", 32'(vld_r), 32'h0);
    rst = 1'b0;
    tick();

    // 1: A4 pulse, ready high -> 7,5,2 on consecutive cycles
    req_f = 8'hA4;
    tick();
    req_f = 8'h00;
    check_eq("t1_pend_after_pulse", 32'(pend_f), 32'hA4);
    check_eq("t1_vld_one_edge", 32'(vld_f), 32'h0);
    tick();
    check_eq("t1_vld_two_edges", 32'(vld_f), 32'h1);
    check_eq("t1_idx7", 32'(idx_f), 32'h7);
    tick();
    check_eq("t1_idx5", 32'(idx_f), 32'h5);
    tick();
    check_eq("t1_idx2", 32'(idx_f), 32'h2);
    check_eq("t1_vld_last", 32'(vld_f), 32'h1);
    check_eq("t1_pend_empty", 32'(pend_f), 32'h0);
    tick();
    check_eq("t1_vld_drop", 32'(vld_f), 32'h0);

    // 2: backpressure holds 7 while 6 accumulates
    rdy_f = 1'b0;
    req_f = 8'h80;
    tick();
    req_f = 8'h40;
    tick();
    req_f = 8'h00;
    check_eq("t2_vld", 32'(vld_f), 32'h1);
    check_eq("t2_idx7", 32'(idx_f), 32'h7);
    check_eq("t2_pend40", 32'(pend_f), 32'h40);
    tick();
    check_eq("t2_idx7_held", 32'(idx_f), 32'h7);
    check_eq("t2_vld_held", 32'(vld_f), 32'h1);
    check_eq("t2_pend40_held", 32'(pend_f), 32'h40);
    rdy_f = 1'b1;
    tick();
    check_eq("t2_idx6", 32'(idx_f), 32'h6);
    check_eq("t2_pend_empty", 32'(pend_f), 32'h0);
    tick();
    check_eq("t2_vld_drop", 32'(vld_f), 32'h0);

    // 4: pulse on a line already pending collapses once
    rdy_f = 1'b0;
    req_f = 8'h80;
    tick();
    req_f = 8'h08;
    tick();
    check_eq("t4_slot7", 32'(idx_f), 32'h7);
    check_eq("t4_pend08", 32'(pend_f), 32'h08);
    check_eq("t4_no_merge_yet", 32'(merge_f), 32'h0);
    tick();
    req_f = 8'h00;
    check_eq("t4_merge", 32'(merge_f), 32'h1);
    check_eq("t4_pend08_kept", 32'(pend_f), 32'h08);
    tick();
    check_eq("t4_merge_pulse", 32'(merge_f), 32'h0);
    rdy_f = 1'b1;
    tick();
    check_eq("t4_idx3", 32'(idx_f), 32'h3);
    check_eq("t4_vld3", 32'(vld_f), 32'h1);
    tick();
    check_eq("t4_idx3_once", 32'(vld_f), 32'h0);

    // 5: re-fire of the line in the slot while it is accepted is a re-arm
    rdy_f = 1'b0;
    req_f = 8'h10;
    tick();
    req_f = 8'h00;
    tick();
    check_eq("t5_slot4", 32'(idx_f), 32'h4);
    check_eq("t5_slot_vld", 32'(vld_f), 32'h1);
    rdy_f = 1'b1;
    req_f = 8'h10;
    tick();
    req_f = 8'h00;
    check_eq("t5_no_merge", 32'(merge_f), 32'h0);
    check_eq("t5_rearm_pend", 32'(pend_f), 32'h10);
    tick();
    check_eq("t5_idx4_again", 32'(idx_f), 32'h4);
    check_eq("t5_vld_again", 32'(vld_f), 32'h1);
    tick();
    check_eq("t5_drained", 32'(vld_f), 32'h0);

    // 3: round-robin; a lone bit 0 first moves the pointer to 0, then FF held
    req_r = 8'h01;
    tick();
    req_r = 8'h00;
    tick();
    check_eq("t3_single_bit", 32'(idx_r), 32'h0);
    check_eq("t3_single_vld", 32'(vld_r), 32'h1);
    req_r = 8'hFF;
    tick();
    tick();
    exp_idx = 3'd7;
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("t3_rr_idx%0d", k), 32'(idx_r), 32'(exp_idx));
      check_eq($sformatf("t3_rr_merge%0d", k), 32'(merge_r), 32'h1);
      exp_idx = exp_idx - 3'd1;
      tick();
    end
    req_r = 8'h00;
    for (int k = 0; k < 10; k++) tick();
    check_eq("t3_rr_drained", 32'(vld_r), 32'h0);

    // 6: reset mid-operation clears everything before the next edge
    rdy_f = 1'b0;
    req_f = 8'h80;
    tick();
    req_f = 8'h81;
    tick();
    req_f = 8'h00;
    check_eq("t6_pre_vld", 32'(vld_f), 32'h1);
    check_eq("t6_pre_pend", 32'(pend_f), 32'h81);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_vld", 32'(vld_f), 32'h0);
    check_eq("t6_rst_pend", 32'(pend_f), 32'h0);
    check_eq("t6_rst_idx", 32'(idx_f), 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    rdy_f = 1'b1;
    tick();
    tick();
    tick();
    check_eq("t6_no_replay_vld", 32'(vld_f), 32'h0);
    check_eq("t6_no_replay_pend", 32'(pend_f), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
